// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the decode/issue slice.
// Opcodes, immediate format selector and width defaults.
package riscv_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDRESS_WIDTH = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_t;

  function automatic imm_type_t imm_sel(
    input logic [6:0] op
  );
    unique case (1'b1)
      op == OP_LOAD,
      op == OP_JALR,
      op == OP_OP_IMM: imm_sel = IMM_I;
      op == OP_STORE:  imm_sel = IMM_S;
      op == OP_BRANCH: imm_sel = IMM_B;
      op == OP_LUI,
      op == OP_AUIPC:  imm_sel = IMM_U;
      op == OP_JAL:    imm_sel = IMM_J;
      default:         imm_sel = IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/decode_issue_imm_gen.sv
// Immediate generator: picks the RV32I format from the opcode
// and returns the sign-extended immediate (0 for other opcodes).
module imm_gen
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [31:0]           instr,
  output imm_type_t             imm_type,
  output logic [DATA_WIDTH-1:0] imm
);

  logic signed [31:0] imm32;

  // Format select and bit gathering per immediate type
  always_comb begin
    imm_type = imm_sel(instr[6:0]);
    imm32    = '0;
    unique case (imm_type)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25],
                      instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31],
                      instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm = DATA_WIDTH'(imm32);
  end

endmodule

// File: rtl/decode_issue.sv
// RV32I decode/issue stage: x0 forcing, hazard stalls, ID/EX reg.
// Build option: WB_BYPASS_EN forwards same-cycle writeback data.
module decode_issue
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [31:0]              id_instr,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [DATA_WIDTH-1:0]    rf_rd1,
  input  logic [DATA_WIDTH-1:0]    rf_rd2,
  input  logic                     wb_we,
  input  logic [ADDRESS_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     ex_ready,
  input  logic                     flush,
  output logic [ADDRESS_WIDTH-1:0] rf_ad1,
  output logic [ADDRESS_WIDTH-1:0] rf_ad2,
  output logic                     id_stall,
  output logic                     ex_valid,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic [DATA_WIDTH-1:0]    ex_rs1_data,
  output logic [DATA_WIDTH-1:0]    ex_rs2_data,
  output logic [DATA_WIDTH-1:0]    ex_imm,
  output logic [ADDRESS_WIDTH-1:0] ex_rd,
  output logic [31:0]              ex_instr,
  output logic                     ex_is_load
);

  logic [ADDRESS_WIDTH-1:0] rs1;
  logic [ADDRESS_WIDTH-1:0] rs2;
  logic [ADDRESS_WIDTH-1:0] rd;
  imm_type_t                imm_type;
  logic [DATA_WIDTH-1:0]    imm;
  logic                     rs1_used;
  logic                     rs2_used;
  logic                     is_load;
  logic                     lu_haz;
  logic                     wb_haz;
  logic [DATA_WIDTH-1:0]    op1;
  logic [DATA_WIDTH-1:0]    op2;

  assign rs1    = ADDRESS_WIDTH'(id_instr[19:15]);
  assign rs2    = ADDRESS_WIDTH'(id_instr[24:20]);
  assign rd     = ADDRESS_WIDTH'(id_instr[11:7]);
  assign rf_ad1 = rs1;
  assign rf_ad2 = rs2;

  imm_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_imm_gen (
    .instr    (id_instr),
    .imm_type (imm_type),
    .imm      (imm)
  );

  // LUI/AUIPC are the U formats and JAL the J format
  assign rs1_used = !(imm_type == IMM_U ||
                      imm_type == IMM_J);
  assign rs2_used = (id_instr[6:0] == OP_OP) ||
                    imm_type == IMM_S ||
                    imm_type == IMM_B;
  assign is_load  = id_instr[6:0] == OP_LOAD;

  // Dependent instruction waits one cycle behind a load in EX
  always_comb begin
    lu_haz = ex_valid && ex_is_load &&
             (ex_rd != '0) && id_valid &&
             ((rs1_used && rs1 == ex_rd) ||
              (rs2_used && rs2 == ex_rd));
  end

`ifdef WB_BYPASS_EN
  // Same-cycle writeback is forwarded, so no collision stall
  always_comb begin
    wb_haz = 1'b0;
    op1 = (rs1 == '0) ? '0 :
          (wb_we && wb_rd == rs1) ? wb_data : rf_rd1;
    op2 = (rs2 == '0) ? '0 :
          (wb_we && wb_rd == rs2) ? wb_data : rf_rd2;
  end
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;

  // Without bypass a writeback collision waits for the RF update
  always_comb begin
    wb_haz = id_valid && wb_we && (wb_rd != '0) &&
             ((rs1_used && rs1 == wb_rd) ||
              (rs2_used && rs2 == wb_rd));
    op1 = (rs1 == '0) ? '0 : rf_rd1;
    op2 = (rs2 == '0) ? '0 : rf_rd2;
  end
`endif

  // Flush overrides every stall source
  assign id_stall = !flush &&
                    (lu_haz || wb_haz ||
                     (id_valid && !ex_ready));

  // ID/EX register: reset, flush, hold, bubble, then load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      ex_instr    <= '0;
      ex_is_load  <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (ex_ready) begin
      if (lu_haz || wb_haz) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid    <= id_valid;
        ex_pc       <= id_pc;
        ex_rs1_data <= op1;
        ex_rs2_data <= op2;
        ex_imm      <= imm;
        ex_rd       <= rd;
        ex_instr    <= id_instr;
        ex_is_load  <= is_load;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios then random traffic
// compared against an encoder-driven behavioural model.
module tb_decode_issue;

  localparam logic [6:0] O_LOAD   = 7'b0000011;
  localparam logic [6:0] O_STORE  = 7'b0100011;
  localparam logic [6:0] O_BRANCH = 7'b1100011;
  localparam logic [6:0] O_JAL    = 7'b1101111;
  localparam logic [6:0] O_JALR   = 7'b1100111;
  localparam logic [6:0] O_LUI    = 7'b0110111;
  localparam logic [6:0] O_AUIPC  = 7'b0010111;
  localparam logic [6:0] O_OP     = 7'b0110011;
  localparam logic [6:0] O_OPIMM  = 7'b0010011;
  localparam logic [6:0] O_SYS    = 7'b1110011;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_ready;
  logic        flush;
  logic [4:0]  rf_ad1;
  logic [4:0]  rf_ad2;
  logic        id_stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic [31:0] ex_instr;
  logic        ex_is_load;

  decode_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .rf_rd1      (rf_rd1),
    .rf_rd2      (rf_rd2),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .ex_ready    (ex_ready),
    .flush       (flush),
    .rf_ad1      (rf_ad1),
    .rf_ad2      (rf_ad2),
    .id_stall    (id_stall),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_rs1_data (ex_rs1_data),
    .ex_rs2_data (ex_rs2_data),
    .ex_imm      (ex_imm),
    .ex_rd       (ex_rd),
    .ex_instr    (ex_instr),
    .ex_is_load  (ex_is_load)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // expected EX contents
  bit          m_known = 0;
  logic        m_valid;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm, m_instr;
  logic [4:0]  m_rd;
  logic        m_load;

  // instruction under construction, with its known meaning
  logic [31:0] g_instr, g_imm;
  logic        g_u1, g_u2, g_load;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mk_r(input logic [4:0] rd, s1, s2);
    g_instr = {7'b0, s2, s1, 3'b000, rd, O_OP};
    g_imm = 0; g_u1 = 1; g_u2 = 1; g_load = 0;
  endtask

  task automatic mk_i(input logic [6:0] op,
                      input logic [4:0] rd, s1,
                      input int imm);
    logic [31:0] v;
    v = imm;
    g_instr = {v[11:0], s1, 3'b010, rd, op};
    g_imm = v; g_u1 = 1; g_u2 = 0;
    g_load = (op == O_LOAD);
  endtask

  task automatic mk_s(input logic [4:0] s1, s2, input int imm);
    logic [31:0] v;
    v = imm;
    g_instr = {v[11:5], s2, s1, 3'b010, v[4:0], O_STORE};
    g_imm = v; g_u1 = 1; g_u2 = 1; g_load = 0;
  endtask

  task automatic mk_b(input logic [4:0] s1, s2, input int imm);
    logic [31:0] v;
    v = imm;
    g_instr = {v[12], v[10:5], s2, s1, 3'b000,
               v[4:1], v[11], O_BRANCH};
    g_imm = v; g_u1 = 1; g_u2 = 1; g_load = 0;
  endtask

  task automatic mk_u(input logic [6:0] op, input logic [4:0] rd,
                      input logic [19:0] hi);
    g_instr = {hi, rd, op};
    g_imm = {hi, 12'b0}; g_u1 = 0; g_u2 = 0; g_load = 0;
  endtask

  task automatic mk_j(input logic [4:0] rd, input int imm);
    logic [31:0] v;
    v = imm;
    g_instr = {v[20], v[10:1], v[11], v[19:12], rd, O_JAL};
    g_imm = v; g_u1 = 0; g_u2 = 0; g_load = 0;
  endtask

  // unknown opcode, rs1 kept at x0 so its usage never matters
  task automatic mk_x(input logic [4:0] rd, s2);
    g_instr = {7'b0, s2, 5'd0, 3'b000, rd, O_SYS};
    g_imm = 0; g_u1 = 1; g_u2 = 0; g_load = 0;
  endtask

  function automatic logic [31:0] resolve(
    input logic [4:0] a, input logic [31:0] rf,
    input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 0;
`ifdef WB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return rf;
  endfunction

  task automatic step(input logic rst, vld,
                      input logic [31:0] pc, rd1, rd2,
                      input logic we, input logic [4:0] wa,
                      input logic [31:0] wd,
                      input logic rdy, fl);
    logic [4:0] s1, s2, d;
    logic lu, wbh, st;
    rst_n = rst; id_valid = vld; id_instr = g_instr;
    id_pc = pc; rf_rd1 = rd1; rf_rd2 = rd2;
    wb_we = we; wb_rd = wa; wb_data = wd;
    ex_ready = rdy; flush = fl;
    s1 = g_instr[19:15]; s2 = g_instr[24:20]; d = g_instr[11:7];
    lu = m_valid && m_load && m_rd != 0 && vld &&
         ((g_u1 && s1 == m_rd) || (g_u2 && s2 == m_rd));
`ifdef WB_BYPASS_EN
    wbh = 0;
`else
    wbh = vld && we && wa != 0 &&
          ((g_u1 && s1 == wa) || (g_u2 && s2 == wa));
`endif
    st = !fl && (lu || wbh || (vld && !rdy));
    #2;
    chk("rf_ad1", 32'(rf_ad1), 32'(s1));
    chk("rf_ad2", 32'(rf_ad2), 32'(s2));
    if (m_known) chk("id_stall", 32'(id_stall), 32'(st));
    if (!rst) begin
      m_known = 1; m_valid = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0;
      m_imm = 0; m_rd = 0; m_instr = 0; m_load = 0;
    end else if (fl) begin
      m_valid = 0;
    end else if (rdy) begin
      if (lu || wbh) m_valid = 0;
      else begin
        m_valid = vld; m_pc = pc;
        m_rs1 = resolve(s1, rd1, we, wa, wd);
        m_rs2 = resolve(s2, rd2, we, wa, wd);
        m_imm = g_imm; m_rd = d; m_instr = g_instr;
        m_load = g_load;
      end
    end
    @(posedge clk);
    #1;
    if (m_known) begin
      chk("ex_valid", 32'(ex_valid), 32'(m_valid));
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_rs1_data", ex_rs1_data, m_rs1);
      chk("ex_rs2_data", ex_rs2_data, m_rs2);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_rd", 32'(ex_rd), 32'(m_rd));
      chk("ex_instr", ex_instr, m_instr);
      chk("ex_is_load", 32'(ex_is_load), 32'(m_load));
    end
  endtask

  task automatic rand_instr();
    logic [4:0] a, b, c;
    int k;
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    c = 5'($urandom_range(0, 7));
    k = $urandom_range(0, 9);
    case (k)
      0: mk_r(a, b, c);
      1: mk_i(O_OPIMM, a, b, int'($urandom_range(0, 4095)) - 2048);
      2: mk_i(O_LOAD, a, b, int'($urandom_range(0, 4095)) - 2048);
      3: mk_s(a, b, int'($urandom_range(0, 4095)) - 2048);
      4: mk_b(a, b, (int'($urandom_range(0, 4095)) - 2048) * 2);
      5: mk_j(a, (int'($urandom_range(0, 1048575)) - 524288) * 2);
      6: mk_i(O_JALR, a, b, int'($urandom_range(0, 4095)) - 2048);
      7: mk_u(O_LUI, a, 20'($urandom));
      8: mk_u(O_AUIPC, a, 20'($urandom));
      default: mk_x(a, c);
    endcase
  endtask

  initial begin
    rst_n = 0; id_valid = 0; id_instr = 0; id_pc = 0;
    rf_rd1 = 0; rf_rd2 = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    ex_ready = 1; flush = 0;
    m_valid = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
    m_rd = 0; m_instr = 0; m_load = 0;
    @(posedge clk);
    #1;

    // reset with a valid instruction presented
    mk_r(5'd1, 5'd2, 5'd3);
    step(0, 1, 32'h40, 32'h1, 32'h2, 0, 0, 0, 1, 0);
    chk("reset_valid", 32'(ex_valid), 32'd0);

    // addi x5,x0,7 with garbage on read port 1
    mk_i(O_OPIMM, 5'd5, 5'd0, 7);
    step(1, 1, 32'h100, 32'hDEADBEEF, 32'h1234, 0, 0, 0, 1, 0);
    chk("plain_imm", ex_imm, 32'd7);
    chk("x0_force", ex_rs1_data, 32'd0);

    // lw x6,0(x1) then add x7,x6,x2
    mk_i(O_LOAD, 5'd6, 5'd1, 0);
    step(1, 1, 32'h104, 32'h1000, 32'h0, 0, 0, 0, 1, 0);
    mk_r(5'd7, 5'd6, 5'd2);
    step(1, 1, 32'h108, 32'hAA, 32'hBB, 0, 0, 0, 1, 0);
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    step(1, 1, 32'h108, 32'hAA, 32'hBB, 0, 0, 0, 1, 0);
    chk("lu_issue", 32'(ex_valid), 32'd1);

    // writeback to x3 while rs1 = x3
    mk_i(O_OPIMM, 5'd8, 5'd3, 1);
    step(1, 1, 32'h10C, 32'h11, 32'h0, 1, 5'd3, 32'h55, 1, 0);
`ifdef WB_BYPASS_EN
    chk("wb_bypass", ex_rs1_data, 32'h55);
`else
    chk("wb_bubble", 32'(ex_valid), 32'd0);
`endif
    step(1, 1, 32'h10C, 32'h55, 32'h0, 0, 0, 0, 1, 0);
    chk("wb_after", ex_rs1_data, 32'h55);

    // flush beats load-use and backpressure
    mk_i(O_LOAD, 5'd6, 5'd1, 8);
    step(1, 1, 32'h110, 32'h2000, 32'h0, 0, 0, 0, 1, 0);
    mk_r(5'd7, 5'd6, 5'd2);
    step(1, 1, 32'h114, 32'h3, 32'h4, 0, 0, 0, 0, 1);
    chk("flush_valid", 32'(ex_valid), 32'd0);

    // three cycles of backpressure, then reset during the hold
    mk_i(O_OPIMM, 5'd9, 5'd1, -5);
    step(1, 1, 32'h118, 32'h77, 32'h0, 0, 0, 0, 1, 0);
    mk_r(5'd10, 5'd9, 5'd9);
    for (int i = 0; i < 3; i++)
      step(1, 1, 32'h11C, 32'h5, 32'h6, 0, 0, 0, 0, 0);
    chk("hold_imm", ex_imm, 32'hFFFFFFFB);
    step(0, 1, 32'h11C, 32'h5, 32'h6, 0, 0, 0, 0, 0);
    chk("rst_hold_pc", ex_pc, 32'd0);

    // load to x0 never stalls a reader of x0
    mk_i(O_LOAD, 5'd0, 5'd1, 4);
    step(1, 1, 32'h200, 32'h10, 32'h0, 0, 0, 0, 1, 0);
    mk_r(5'd7, 5'd0, 5'd0);
    step(1, 1, 32'h204, 32'h1, 32'h2, 0, 0, 0, 1, 0);
    chk("ld_x0_issue", 32'(ex_valid), 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_instr();
      step($urandom_range(0, 49) != 0,
           $urandom_range(0, 9) != 0,
           $urandom, $urandom, $urandom,
           1'($urandom),
           5'($urandom_range(0, 7)),
           $urandom,
           $urandom_range(0, 4) != 0,
           $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
